// File: rtl/alsu_cmd_sequencer_pkg.sv
// rtl/alsu_cmd_sequencer_pkg.sv - ALSU opcodes, control-pin layout and command record
package alsu_cmd_sequencer_pkg;

  localparam logic [2:0] OP_AND    = 3'd0;
  localparam logic [2:0] OP_XOR    = 3'd1;
  localparam logic [2:0] OP_ADD    = 3'd2;
  localparam logic [2:0] OP_MULT   = 3'd3;
  localparam logic [2:0] OP_SHIFT  = 3'd4;
  localparam logic [2:0] OP_ROTATE = 3'd5;

  localparam int CTRL_W        = 7;
  localparam int CTRL_CIN      = 6;
  localparam int CTRL_SERIAL   = 5;
  localparam int CTRL_DIR      = 4;
  localparam int CTRL_RED_A    = 3;
  localparam int CTRL_RED_B    = 2;
  localparam int CTRL_BYPASS_A = 1;
  localparam int CTRL_BYPASS_B = 0;

  localparam int CMD_W = 3 + 3 + 3 + CTRL_W;

  typedef struct packed {
    logic [2:0]        a;
    logic [2:0]        b;
    logic [2:0]        opcode;
    logic [CTRL_W-1:0] ctrl;
  } alsu_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alsu_cmd_sequencer_if.sv
// rtl/alsu_cmd_sequencer_if.sv - command, ALSU drive and result signals of the sequencer
interface alsu_cmd_sequencer_if
  import alsu_cmd_sequencer_pkg::*;
#(
  parameter int TAG_W = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_a;
  logic [2:0]        cmd_b;
  logic [2:0]        cmd_opcode;
  logic [CTRL_W-1:0] cmd_ctrl;
  logic [TAG_W-1:0]  cmd_tag;

  logic [2:0]        alsu_A;
  logic [2:0]        alsu_B;
  logic [2:0]        alsu_opcode;
  logic [CTRL_W-1:0] alsu_ctrl;
  logic [5:0]        alsu_out;
  logic [15:0]       alsu_leds;

  logic              res_valid;
  logic              res_ready;
  logic [5:0]        res_data;
  logic [TAG_W-1:0]  res_tag;
  logic              res_err;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_opcode, cmd_ctrl, cmd_tag,
    input  alsu_out, alsu_leds, res_ready,
    output cmd_ready, alsu_A, alsu_B, alsu_opcode, alsu_ctrl,
    output res_valid, res_data, res_tag, res_err
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_opcode, cmd_ctrl, cmd_tag,
    output alsu_out, alsu_leds, res_ready,
    input  cmd_ready, alsu_A, alsu_B, alsu_opcode, alsu_ctrl,
    input  res_valid, res_data, res_tag, res_err
  );
endinterface

// File: rtl/alsu_cmd_sequencer_sync_fifo.sv
// rtl/alsu_cmd_sequencer_sync_fifo.sv - show-ahead synchronous FIFO with wrap-bit pointers
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end
endmodule

// File: rtl/alsu_cmd_sequencer.sv
// rtl/alsu_cmd_sequencer.sv - queues tagged ALSU commands, issues one at a time, returns results
module alsu_cmd_sequencer
  import alsu_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int ALSU_LAT = 2,
  parameter int TAG_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  alsu_cmd_sequencer_if.slave  bus
);
  localparam int CNT_W  = $clog2(ALSU_LAT + 1);
  localparam int FIFO_W = CMD_W + TAG_W;

  seq_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [FIFO_W-1:0] fifo_wdata;
  logic [FIFO_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  alsu_cmd_t         head;
  logic [TAG_W-1:0]  head_tag;
  alsu_cmd_t         drive_q;
  logic [TAG_W-1:0]  flight_tag;
  logic              res_valid_q;
  logic [5:0]        res_data_q;
  logic [TAG_W-1:0]  res_tag_q;
  logic              res_err_q;

  assign fifo_wdata = {bus.cmd_tag, bus.cmd_a, bus.cmd_b, bus.cmd_opcode, bus.cmd_ctrl};
  assign {head_tag, head} = fifo_rdata;
  assign push = bus.cmd_valid && !fifo_full;
  // A new command is issued from IDLE, or on the same edge a held result is consumed.
  assign pop  = !fifo_empty &&
                ((state == ST_IDLE) || (state == ST_HOLD && res_valid_q && bus.res_ready));

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      drive_q     <= '0;
      flight_tag  <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
      res_err_q   <= 1'b0;
    end else begin
      if (pop) begin
        drive_q    <= head;
        flight_tag <= head_tag;
        cnt        <= CNT_W'(ALSU_LAT);
      end
      case (state)
        ST_IDLE: begin
          if (pop) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            res_data_q  <= bus.alsu_out;
            res_tag_q   <= flight_tag;
            res_err_q   <= |bus.alsu_leds;
            res_valid_q <= 1'b1;
            state       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (res_valid_q && bus.res_ready) begin
            res_valid_q <= 1'b0;
            state       <= pop ? ST_WAIT : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = !fifo_full;
  assign bus.alsu_A      = drive_q.a;
  assign bus.alsu_B      = drive_q.b;
  assign bus.alsu_opcode = drive_q.opcode;
  assign bus.alsu_ctrl   = drive_q.ctrl;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_tag     = res_tag_q;
  assign bus.res_err     = res_err_q;
endmodule

// File: tb/tb_alsu_cmd_sequencer.sv
// tb/tb_alsu_cmd_sequencer.sv - directed self-checking bench with a two-stage ALSU model
module tb_alsu_cmd_sequencer;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;

  alsu_cmd_sequencer_if #(.TAG_W(4)) bus ();

  alsu_cmd_sequencer #(
    .DEPTH    (4),
    .ALSU_LAT (2),
    .TAG_W    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic alsu_inv(input logic [2:0] op, input logic [6:0] c);
    return (op > 3'd5) || ((c[3] || c[2]) && (op > 3'd1));
  endfunction

  function automatic logic [5:0] alsu_f(input logic [2:0] a, input logic [2:0] b,
                                        input logic [2:0] op, input logic [6:0] c,
                                        input logic [5:0] prev);
    if (alsu_inv(op, c)) return 6'd0;
    if (c[1]) return {3'b0, a};
    if (c[0]) return {3'b0, b};
    case (op)
      3'd0: return c[3] ? {5'b0, &a} : c[2] ? {5'b0, &b} : {3'b0, a & b};
      3'd1: return c[3] ? {5'b0, ^a} : c[2] ? {5'b0, ^b} : {3'b0, a ^ b};
      3'd2: return {3'b0, a} + {3'b0, b} + {5'b0, c[6]};
      3'd3: return {3'b0, a} * {3'b0, b};
      3'd4: return c[4] ? {prev[4:0], c[5]} : {c[5], prev[5:1]};
      default: return c[4] ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
    endcase
  endfunction

  // ALSU stand-in: input register stage then output register stage.
  logic [2:0] m_a, m_b, m_op;
  logic [6:0] m_c;
  logic [5:0] m_out;
  logic [15:0] m_leds;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_a <= 0; m_b <= 0; m_op <= 0; m_c <= 0; m_out <= 0; m_leds <= 0;
    end else begin
      m_a <= bus.alsu_A; m_b <= bus.alsu_B; m_op <= bus.alsu_opcode; m_c <= bus.alsu_ctrl;
      m_out  <= alsu_f(m_a, m_b, m_op, m_c, m_out);
      m_leds <= alsu_inv(m_op, m_c) ? 16'hFFFF : 16'h0000;
    end
  end
  assign bus.alsu_out  = m_out;
  assign bus.alsu_leds = m_leds;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op,
                      input logic [6:0] c, input logic [3:0] tag);
    int n;
    bus.cmd_a = a; bus.cmd_b = b; bus.cmd_opcode = op; bus.cmd_ctrl = c; bus.cmd_tag = tag;
    bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin tick(); n++; end
    chk("send_timeout", n < 50, 1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_one(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op,
                         input logic [6:0] c, input logic [3:0] tag,
                         output logic [5:0] d, output logic [3:0] t, output logic e);
    int n;
    send(a, b, op, c, tag);
    n = 0;
    while (!bus.res_valid && n < 30) begin tick(); n++; end
    chk("result_timeout", n < 30, 1);
    d = bus.res_data; t = bus.res_tag; e = bus.res_err;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  logic [5:0] d;
  logic [3:0] t;
  logic       e;
  int         acc, n, got, sent, last, seen;
  logic       acc_now;
  logic [2:0] sa [6];
  logic [2:0] sb [6];
  logic [2:0] so [6];
  logic [6:0] sc [6];
  logic [5:0] se [6];

  initial begin
    total = 0; bad = 0; cyc = 0;
    rst = 1'b1;
    bus.cmd_valid = 0; bus.cmd_a = 0; bus.cmd_b = 0; bus.cmd_opcode = 0;
    bus.cmd_ctrl = 0; bus.cmd_tag = 0; bus.res_ready = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data",  bus.res_data, 0);
    chk("rst_res_tag",   bus.res_tag, 0);
    chk("rst_res_err",   bus.res_err, 0);
    chk("rst_alsu",      {bus.alsu_A, bus.alsu_B, bus.alsu_opcode, bus.alsu_ctrl}, 0);

    // Latency: accept edge 0, drive after edge 1, result after edge 4.
    send(3'b101, 3'b011, 3'b000, 7'b0, 4'd3);
    tick();
    chk("lat_alsu_A", bus.alsu_A, 3'b101);
    chk("lat_alsu_B", bus.alsu_B, 3'b011);
    chk("lat_e1_valid", bus.res_valid, 0);
    tick(); tick();
    chk("lat_e3_valid", bus.res_valid, 0);
    tick();
    chk("lat_e4_valid", bus.res_valid, 1);
    chk("lat_data", bus.res_data, 6'b000001);
    chk("lat_tag", bus.res_tag, 3);
    chk("lat_err", bus.res_err, 0);
    tick();
    chk("hold_valid", bus.res_valid, 1);
    chk("hold_data", bus.res_data, 6'b000001);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    chk("release_valid", bus.res_valid, 0);
    chk("alsu_held", bus.alsu_A, 3'b101);

    run_one(3'b111, 3'b001, 3'b001, 7'b0001000, 4'd1, d, t, e);
    chk("xor_red_a", d, 6'b000001);
    run_one(3'b111, 3'b001, 3'b001, 7'b0000000, 4'd2, d, t, e);
    chk("xor_plain", d, 6'b000110);
    run_one(3'b010, 3'b011, 3'b111, 7'b0000000, 4'd9, d, t, e);
    chk("inv_err", e, 1);
    chk("inv_tag", t, 9);
    chk("inv_data", d, 0);
    run_one(3'b011, 3'b100, 3'b010, 7'b1000000, 4'd10, d, t, e);
    chk("valid_err", e, 0);
    chk("add_cin", d, 6'b001000);
    chk("add_tag", t, 10);

    // Backpressure: one in flight plus DEPTH queued.
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      bus.cmd_a = acc[2:0]; bus.cmd_b = 3'd1; bus.cmd_opcode = 3'd2; bus.cmd_ctrl = 7'd0;
      bus.cmd_tag = acc[3:0];
      bus.cmd_valid = (acc < 6);
      acc_now = bus.cmd_ready && (acc < 6);
      tick();
      if (acc_now) acc++;
    end
    chk("bp_accepted", acc, 5);
    chk("bp_cmd_ready", bus.cmd_ready, 0);
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (!bus.res_valid && n < 30) begin tick(); n++; end
      chk("bp_timeout", n < 30, 1);
      chk($sformatf("bp_tag%0d", k), bus.res_tag, k);
      chk($sformatf("bp_data%0d", k), bus.res_data, k + 1);
      tick();
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (bus.res_valid) seen++; end
    chk("bp_drained", seen, 0);
    chk("bp_ready_again", bus.cmd_ready, 1);

    // Continuous stream: one result every ALSU_LAT+2 cycles.
    sa[0]=3'd5; sb[0]=3'd3; so[0]=3'd0; sc[0]=7'b0000000; se[0]=6'd1;
    sa[1]=3'd6; sb[1]=3'd3; so[1]=3'd1; sc[1]=7'b0000000; se[1]=6'd5;
    sa[2]=3'd7; sb[2]=3'd7; so[2]=3'd2; sc[2]=7'b1000000; se[2]=6'd15;
    sa[3]=3'd7; sb[3]=3'd6; so[3]=3'd3; sc[3]=7'b0000000; se[3]=6'd42;
    sa[4]=3'd2; sb[4]=3'd5; so[4]=3'd2; sc[4]=7'b0000000; se[4]=6'd7;
    sa[5]=3'd4; sb[5]=3'd1; so[5]=3'd0; sc[5]=7'b0000001; se[5]=6'd1;
    sent = 0; got = 0; last = 0;
    for (int c = 0; c < 200 && got < 6; c++) begin
      if (bus.res_valid) begin
        chk($sformatf("st_data%0d", got), bus.res_data, se[got]);
        chk($sformatf("st_tag%0d", got), bus.res_tag, got + 4);
        if (got > 0) chk($sformatf("st_gap%0d", got), cyc - last, 4);
        last = cyc;
        got++;
      end
      acc_now = (sent < 6) && bus.cmd_ready;
      if (sent < 6) begin
        bus.cmd_a = sa[sent]; bus.cmd_b = sb[sent]; bus.cmd_opcode = so[sent];
        bus.cmd_ctrl = sc[sent]; bus.cmd_tag = 4'(sent + 4); bus.cmd_valid = 1'b1;
      end else begin
        bus.cmd_valid = 1'b0;
      end
      tick();
      if (acc_now) sent++;
    end
    bus.cmd_valid = 1'b0;
    chk("st_count", got, 6);

    // Reset with work in flight and queued.
    bus.res_ready = 1'b0;
    send(3'd1, 3'd2, 3'd2, 7'd0, 4'd7);
    send(3'd3, 3'd3, 3'd3, 7'd0, 4'd8);
    tick();
    rst = 1'b1;
    tick(); tick();
    chk("mid_rst_valid", bus.res_valid, 0);
    chk("mid_rst_ready", bus.cmd_ready, 1);
    chk("mid_rst_alsu", {bus.alsu_A, bus.alsu_B, bus.alsu_opcode, bus.alsu_ctrl}, 0);
    chk("mid_rst_res", {bus.res_data, bus.res_tag, bus.res_err}, 0);
    rst = 1'b0;
    bus.res_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin tick(); if (bus.res_valid) seen++; end
    chk("mid_rst_no_result", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
